// File: rtl/pio_pkg.sv
// Shared definitions for the PIO instruction memory block.
//   INSTR_MEM_BASE : byte address of INSTR_MEM0 (words at +4*k)
//   SM_INSTR_BASE  : byte address of SM0_INSTR
//   SM_STRIDE      : byte distance between consecutive SMn_INSTR registers
//   DEPTH, DATA_W  : default program depth and instruction width
//   instr_t        : one instruction word
//   even_parity()  : parity bit that makes a stored word plus its bit even
package pio_pkg;

    localparam logic [11:0] INSTR_MEM_BASE = 12'h048;
    localparam logic [11:0] SM_INSTR_BASE  = 12'h0D8;
    localparam logic [11:0] SM_STRIDE      = 12'h018;

    localparam int DEPTH  = 32;
    localparam int DATA_W = 16;

    typedef logic [15:0] instr_t;

    function automatic logic even_parity(input instr_t w);
        return ^w;
    endfunction

endpackage

// File: rtl/pio_force_reg.sv
// Forced-instruction register for one state machine.
// A write loads the holding register and raises flag for exactly the next
// cycle; jmp_data keeps the last written word until the next write.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en        : one-cycle write strobe (already qualified by the bus decode)
//   wr_data      : instruction word to force
//   jmp_data     : held forced instruction
//   flag         : one-cycle pulse following each write
module pio_force_reg
    import pio_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] jmp_data,
    output logic              flag
);

    logic [DATA_W-1:0] jmp_q, jmp_d;
    logic              flag_q, flag_d;

    always_comb begin
        jmp_d  = jmp_q;
        flag_d = wr_en;
        if (wr_en) begin
            jmp_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jmp_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            jmp_q  <= jmp_d;
            flag_q <= flag_d;
        end
    end

    assign jmp_data = jmp_q;
    assign flag     = flag_q;

endmodule

// File: rtl/pio_instr_mem.sv
// PIO instruction memory with APB program loader and per-SM fetch ports.
// DEPTH words of DATA_W bits, written through INSTR_MEMk; each of NUM_SM
// fetch ports reads independently with one cycle of latency. Also hosts the
// SMn_INSTR forced-execution registers (one pio_force_reg per SM).
// Optional build macro PIO_MEM_PARITY_EN adds a stored even-parity bit per
// word and the parity_err output.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   psel/penable/pwrite/paddr/pwdata : APB request (write-only register map)
//   prdata, pready, pslverr       : APB response (prdata always 0)
//   pc, rd                        : fetch address and request per SM
//   instr_data, instr_valid       : fetched word per SM, valid for one cycle
//   flag_abnormal, jmp_data       : forced-instruction pulse and word per SM
//   parity_err                    : (PIO_MEM_PARITY_EN) fetched word parity bad
module pio_instr_mem #(
    parameter int NUM_SM = 4,
    parameter int DEPTH  = 32,
    parameter int DATA_W = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            psel,
    input  logic                            penable,
    input  logic                            pwrite,
    input  logic [11:0]                     paddr,
    input  logic [31:0]                     pwdata,
    output logic [31:0]                     prdata,
    output logic                            pready,
    output logic                            pslverr,
    input  logic [NUM_SM*$clog2(DEPTH)-1:0] pc,
    input  logic [NUM_SM-1:0]               rd,
    output logic [NUM_SM*DATA_W-1:0]        instr_data,
    output logic [NUM_SM-1:0]               instr_valid,
`ifdef PIO_MEM_PARITY_EN
    output logic [NUM_SM-1:0]               parity_err,
`endif
    output logic [NUM_SM-1:0]               flag_abnormal,
    output logic [NUM_SM*DATA_W-1:0]        jmp_data
);

    import pio_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);
`ifdef PIO_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [11:0] MEM_END = INSTR_MEM_BASE + 12'(DEPTH * 4);

    logic [MEM_W-1:0]  mem_q [DEPTH];
    logic [MEM_W-1:0]  mem_d [DEPTH];
    logic [DATA_W-1:0] instr_data_q [NUM_SM];
    logic [DATA_W-1:0] instr_data_d [NUM_SM];
    logic [NUM_SM-1:0] instr_valid_q, instr_valid_d;
`ifdef PIO_MEM_PARITY_EN
    logic [NUM_SM-1:0] parity_err_q, parity_err_d;
`endif

    logic              wr_access;
    logic              mem_hit;
    logic [NUM_SM-1:0] sm_hit;
    logic [11:0]       mem_off;
    logic [ADDR_W-1:0] wr_idx;
    logic [MEM_W-1:0]  wr_word;
    logic              unused_bits;

    // Bus decode: only the APB access phase of a write can change state.
    always_comb begin
        wr_access = psel & penable & pwrite;
        mem_off   = paddr - INSTR_MEM_BASE;
        wr_idx    = mem_off[ADDR_W+1:2];
        mem_hit   = wr_access && (paddr >= INSTR_MEM_BASE) && (paddr < MEM_END)
                    && (paddr[1:0] == 2'b00);
        for (int n = 0; n < NUM_SM; n++) begin
            sm_hit[n] = wr_access && (paddr == SM_INSTR_BASE + SM_STRIDE * 12'(n));
        end
`ifdef PIO_MEM_PARITY_EN
        wr_word = {even_parity(pwdata[DATA_W-1:0]), pwdata[DATA_W-1:0]};
`else
        wr_word = pwdata[DATA_W-1:0];
`endif
    end

    assign pslverr     = wr_access & ~mem_hit & ~(|sm_hit);
    assign prdata      = '0;
    assign pready      = 1'b1;
    assign unused_bits = ^{pwdata[31:DATA_W], mem_off[11:ADDR_W+2], mem_off[1:0]};

    // Program store update.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (mem_hit) begin
            mem_d[wr_idx] = wr_word;
        end
    end

    // Fetch ports. A write landing on the fetched address in the same cycle
    // is forwarded so the SM never sees the stale word.
    always_comb begin
        logic [ADDR_W-1:0] pc_n;
        logic [MEM_W-1:0]  word;
        pc_n = '0;
        word = '0;
        instr_valid_d = rd;
`ifdef PIO_MEM_PARITY_EN
        parity_err_d = '0;
`endif
        for (int n = 0; n < NUM_SM; n++) begin
            instr_data_d[n] = instr_data_q[n];
            pc_n = pc[n*ADDR_W +: ADDR_W];
            word = (mem_hit && (wr_idx == pc_n)) ? wr_word : mem_q[pc_n];
            if (rd[n]) begin
                instr_data_d[n] = word[DATA_W-1:0];
`ifdef PIO_MEM_PARITY_EN
                parity_err_d[n] = ^word;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int n = 0; n < NUM_SM; n++) begin
                instr_data_q[n] <= '0;
            end
            instr_valid_q <= '0;
`ifdef PIO_MEM_PARITY_EN
            parity_err_q  <= '0;
`endif
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            for (int n = 0; n < NUM_SM; n++) begin
                instr_data_q[n] <= instr_data_d[n];
            end
            instr_valid_q <= instr_valid_d;
`ifdef PIO_MEM_PARITY_EN
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign instr_valid = instr_valid_q;
`ifdef PIO_MEM_PARITY_EN
    assign parity_err  = parity_err_q;
`endif

    for (genvar n = 0; n < NUM_SM; n++) begin : g_sm
        assign instr_data[n*DATA_W +: DATA_W] = instr_data_q[n];

        pio_force_reg u_force (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr_en    (sm_hit[n]),
            .wr_data  (pwdata[DATA_W-1:0]),
            .jmp_data (jmp_data[n*DATA_W +: DATA_W]),
            .flag     (flag_abnormal[n])
        );
    end

endmodule
